// File: rtl/prco_decode_stage.sv
// Handshaked PRCO instruction decoder: valid/ready in, registered decode bundle out.
// Define PRCO_DEC_SKID_EN to add a one-entry skid register and a flopped q_ready.
module prco_decode_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              q_ready,
    input  logic [15:0]       i_instr,
    output logic              q_valid,
    input  logic              i_ready,
    output logic [4:0]        q_op,
    output logic [2:0]        q_seld,
    output logic [2:0]        q_sela,
    output logic [DATA_W-1:0] q_imm,
    output logic              q_reg_we,
    output logic              q_mem_we,
    output logic              q_flags_we,
    output logic              q_branch,
    output logic              q_illegal,
    output logic [CNT_W-1:0]  q_illegal_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    typedef struct packed {
        logic [4:0]        op;
        logic [2:0]        seld;
        logic [2:0]        sela;
        logic [DATA_W-1:0] imm;
        logic              reg_we;
        logic              mem_we;
        logic              flags_we;
        logic              branch;
        logic              illegal;
    } bundle_t;

    // Fill-then-overwrite keeps the extension valid down to DATA_W = 8.
    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        logic [DATA_W-1:0] r;
        r      = {DATA_W{v[7]}};
        r[7:0] = v;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
        logic [DATA_W-1:0] r;
        r      = '0;
        r[7:0] = v;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
        logic [DATA_W-1:0] r;
        r      = {DATA_W{v[4]}};
        r[4:0] = v;
        return r;
    endfunction

    function automatic bundle_t decode(input logic [15:0] instr);
        bundle_t d;
        d      = '0;
        d.op   = instr[15:11];
        d.seld = instr[10:8];
        d.sela = instr[7:5];
        case (instr[15:11])
            5'h00: ;
            5'h01: begin d.reg_we = 1'b1; d.imm = zext8(instr[7:0]); end
            5'h02, 5'h03, 5'h04: d.reg_we = 1'b1;
            5'h05: d.flags_we = 1'b1;
            5'h06: begin d.reg_we = 1'b1; d.imm = sext5(instr[4:0]); end
            5'h07: begin d.mem_we = 1'b1; d.imm = sext5(instr[4:0]); end
            5'h08: begin d.branch = 1'b1; d.imm = sext8(instr[7:0]); end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    bundle_t          main_q;
    bundle_t          dec_in;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, drain, load_main;
`ifdef PRCO_DEC_SKID_EN
    bundle_t          skid_q;
    logic             ready_q;
    logic             load_skid, main_from_skid;
`endif

    assign dec_in  = decode(i_instr);
    assign q_valid = (state_q != ST_EMPTY);
`ifdef PRCO_DEC_SKID_EN
    assign q_ready = ready_q && i_rst_n;
`else
    assign q_ready = i_rst_n && (!q_valid || i_ready);
`endif
    assign accept  = i_valid && q_ready;
    assign drain   = q_valid && i_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
`ifdef PRCO_DEC_SKID_EN
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: if (accept) begin
                load_main = 1'b1;
                state_d   = ST_ONE;
            end
            ST_ONE: begin
`ifdef PRCO_DEC_SKID_EN
                if (accept && !drain) begin
                    load_skid = 1'b1;
                    state_d   = ST_TWO;
                end else
`endif
                if (accept) load_main = 1'b1;
                else if (drain) state_d = ST_EMPTY;
            end
`ifdef PRCO_DEC_SKID_EN
            ST_TWO: if (drain) begin
                main_from_skid = 1'b1;
                state_d        = ST_ONE;
            end
`endif
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses nonblocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            cnt_q   <= '0;
`ifdef PRCO_DEC_SKID_EN
            skid_q  <= '0;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (load_main) main_q <= dec_in;
`ifdef PRCO_DEC_SKID_EN
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid) skid_q <= dec_in;
            ready_q <= (state_d != ST_TWO);
`endif
            if (accept && dec_in.illegal && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign q_op          = main_q.op;
    assign q_seld        = main_q.seld;
    assign q_sela        = main_q.sela;
    assign q_imm         = main_q.imm;
    assign q_reg_we      = main_q.reg_we;
    assign q_mem_we      = main_q.mem_we;
    assign q_flags_we    = main_q.flags_we;
    assign q_branch      = main_q.branch;
    assign q_illegal     = main_q.illegal;
    assign q_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_prco_decode_stage.sv
// Directed testbench for prco_decode_stage (DATA_W = 16, CNT_W = 8).
module tb_prco_decode_stage;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
`ifdef PRCO_DEC_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              q_ready;
    logic [15:0]       i_instr;
    logic              q_valid;
    logic              i_ready;
    logic [4:0]        q_op;
    logic [2:0]        q_seld;
    logic [2:0]        q_sela;
    logic [DATA_W-1:0] q_imm;
    logic              q_reg_we, q_mem_we, q_flags_we, q_branch, q_illegal;
    logic [CNT_W-1:0]  q_illegal_cnt;

    int errors = 0;
    int checks = 0;

    prco_decode_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .q_ready(q_ready),
        .i_instr(i_instr), .q_valid(q_valid), .i_ready(i_ready), .q_op(q_op),
        .q_seld(q_seld), .q_sela(q_sela), .q_imm(q_imm), .q_reg_we(q_reg_we),
        .q_mem_we(q_mem_we), .q_flags_we(q_flags_we), .q_branch(q_branch),
        .q_illegal(q_illegal), .q_illegal_cnt(q_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Bundle packed as {op, seld, sela, imm, reg_we, mem_we, flags_we, branch, illegal}.
    function automatic logic [31:0] obs();
        return {q_op, q_seld, q_sela, q_imm, q_reg_we, q_mem_we, q_flags_we, q_branch, q_illegal};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] instr);
        i_valid = 1'b1;
        i_instr = instr;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_instr = 16'h0AF0;
        i_ready = 1'b1;
        #1;
        checks++;
        if (q_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", q_ready); end
        step();
        step();
        checks++;
        if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", q_valid); end
        checks++;
        if (obs() !== 32'h0) begin errors++; $display("FAIL reset_bundle got %h want 0", obs()); end
        checks++;
        if (q_illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", q_illegal_cnt); end
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        #1;
        checks++;
        if (q_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", q_ready); end
    endtask

    task automatic test_decode();
        logic [15:0] instrs [9];
        logic [31:0] exps   [9];
        instrs = '{16'h0AF0, 16'h317E, 16'h40FC, 16'h3801, 16'h2800,
                   16'h00FF, 16'h1B45, 16'h1000, 16'h2000};
        exps   = '{{5'h01, 3'd2, 3'd7, 16'h00F0, 5'b10000},
                   {5'h06, 3'd1, 3'd3, 16'hFFFE, 5'b10000},
                   {5'h08, 3'd0, 3'd7, 16'hFFFC, 5'b00010},
                   {5'h07, 3'd0, 3'd0, 16'h0001, 5'b01000},
                   {5'h05, 3'd0, 3'd0, 16'h0000, 5'b00100},
                   {5'h00, 3'd0, 3'd7, 16'h0000, 5'b00000},
                   {5'h03, 3'd3, 3'd2, 16'h0000, 5'b10000},
                   {5'h02, 3'd0, 3'd0, 16'h0000, 5'b10000},
                   {5'h04, 3'd0, 3'd0, 16'h0000, 5'b10000}};
        for (int i = 0; i < 9; i++) begin
            send(instrs[i]);
            checks++;
            if (q_valid !== 1'b1 || obs() !== exps[i]) begin
                errors++;
                $display("FAIL decode_%h got valid=%b bundle=%h want valid=1 bundle=%h",
                         instrs[i], q_valid, obs(), exps[i]);
            end
        end
        step();
        checks++;
        if (q_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got %b want 0", q_valid); end
    endtask

    task automatic test_illegal();
        send(16'hF800);
        checks++;
        if (obs() !== {5'h1F, 3'd0, 3'd0, 16'h0000, 5'b00001} || q_illegal_cnt !== 8'd1) begin
            errors++;
            $display("FAIL illegal_1f got bundle=%h cnt=%0d want bundle=%h cnt=1",
                     obs(), q_illegal_cnt, {5'h1F, 3'd0, 3'd0, 16'h0000, 5'b00001});
        end
        send(16'h4800);
        checks++;
        if (obs() !== {5'h09, 3'd0, 3'd0, 16'h0000, 5'b00001} || q_illegal_cnt !== 8'd2) begin
            errors++;
            $display("FAIL illegal_09 got bundle=%h cnt=%0d want bundle=%h cnt=2",
                     obs(), q_illegal_cnt, {5'h09, 3'd0, 3'd0, 16'h0000, 5'b00001});
        end
        step();
        checks++;
        if (q_illegal_cnt !== 8'd2) begin errors++; $display("FAIL illegal_hold got %0d want 2", q_illegal_cnt); end
    endtask

    task automatic test_stall_stream();
        int          sent = 0;
        int          rcv = 0;
        logic        prev_stalled = 1'b0;
        logic [31:0] prev_obs = '0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            i_ready = (cyc >= 3);
            i_valid = (sent < 4);
            i_instr = 16'h0800 | 16'(sent + 1);
            #1;
            if (prev_stalled) begin
                checks++;
                if (obs() !== prev_obs) begin
                    errors++;
                    $display("FAIL stall_stable got %h want %h", obs(), prev_obs);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (sent != STALL_ACCEPTS || q_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_accepts got %0d ready=%b want %0d ready=0",
                             sent, q_ready, STALL_ACCEPTS);
                end
            end
            if (q_valid && i_ready) begin
                checks++;
                if (q_imm !== 16'(rcv + 1) || q_op !== 5'h01) begin
                    errors++;
                    $display("FAIL stream_order got op=%h imm=%h want op=01 imm=%h",
                             q_op, q_imm, 16'(rcv + 1));
                end
                rcv++;
            end
            prev_stalled = q_valid && !i_ready;
            prev_obs     = obs();
            if (i_valid && q_ready) sent++;
            step();
        end
        checks++;
        if (rcv != 4) begin errors++; $display("FAIL stream_timeout got %0d bundles want 4", rcv); end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        i_valid = 1'b1;
        i_instr = 16'hF800;
        i_ready = 1'b1;
        repeat (252) step();
        checks++;
        if (q_illegal_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", q_illegal_cnt); end
        step();
        checks++;
        if (q_illegal_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", q_illegal_cnt); end
        repeat (47) step();
        checks++;
        if (q_illegal_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", q_illegal_cnt); end
        i_valid = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        i_valid = 1'b1;
        i_instr = 16'hF800;
        i_ready = 1'b1;
        repeat (5) step();
        i_ready = 1'b0;
        i_instr = 16'h0801;
        repeat (2) step();
        i_valid = 1'b0;
        #1;
        checks++;
        if (q_valid !== 1'b1 || q_illegal_cnt !== 8'd5) begin
            errors++;
            $display("FAIL midrst_pre got valid=%b cnt=%0d want valid=1 cnt=5", q_valid, q_illegal_cnt);
        end
`ifdef PRCO_DEC_SKID_EN
        checks++;
        if (q_ready !== 1'b0) begin errors++; $display("FAIL midrst_two_ready got %b want 0", q_ready); end
`endif
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_instr = 16'hF800;
        #1;
        checks++;
        if (q_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low got %b want 0", q_ready); end
        step();
        checks++;
        if (q_valid !== 1'b0 || q_illegal_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_post got valid=%b cnt=%0d want valid=0 cnt=0", q_valid, q_illegal_cnt);
        end
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        #1;
        checks++;
        if (q_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_high got %b want 1", q_ready); end
        step();
        checks++;
        if (q_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_ghost got %b want 0", q_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_stall_stream();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
